// File: rtl/draw_sequencer.sv
// Frame draw sequencer: walks MAP -> PLAYER [-> HUD] -> DONE and muxes the active client's pixel bus.
// Define DRAW_SEQUENCER_HUD_EN to build the HUD stage and its hud_* ports.
module draw_sequencer #(
    parameter logic [16:0] TIMEOUT_CYCLES = 17'd100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       clear_flags,
    output logic       map_enable,
    output logic       player_enable,
    input  logic       map_done,
    input  logic       player_done,
    input  logic [8:0] map_x,
    input  logic [8:0] player_x,
    input  logic [7:0] map_y,
    input  logic [7:0] player_y,
    input  logic [5:0] map_colour,
    input  logic [5:0] player_colour,
    input  logic       map_write,
    input  logic       player_write,
`ifdef DRAW_SEQUENCER_HUD_EN
    output logic       hud_enable,
    input  logic       hud_done,
    input  logic [8:0] hud_x,
    input  logic [7:0] hud_y,
    input  logic [5:0] hud_colour,
    input  logic       hud_write,
`endif
    output logic [8:0] x_pos,
    output logic [7:0] y_pos,
    output logic [5:0] colour,
    output logic       VGA_write,
    output logic       busy,
    output logic [1:0] stage,
    output logic       frame_done,
    output logic       frame_overrun,
    output logic       stage_timeout
);

`ifdef DRAW_SEQUENCER_HUD_EN
    localparam int NUM_CLIENTS = 3;
`else
    localparam int NUM_CLIENTS = 2;
`endif
    localparam int BUS_W = 24;

    // Stage states are encoded so their low two bits equal the stage code.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MAP    = 3'd1;
    localparam logic [2:0] S_PLAYER = 3'd2;
`ifdef DRAW_SEQUENCER_HUD_EN
    localparam logic [2:0] S_HUD    = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state_reg, state_next;
    logic [16:0] count_reg, count_next;
    logic        overrun_reg, overrun_next;
    logic        timeout_reg, timeout_next;
    logic        active_done;
    logic        in_stage;
    logic [2:0]  after_stage;

    always_comb begin
        active_done = 1'b0;
        in_stage    = 1'b0;
        after_stage = S_DONE;
        case (state_reg)
            S_MAP: begin
                active_done = map_done;
                in_stage    = 1'b1;
                after_stage = S_PLAYER;
            end
            S_PLAYER: begin
                active_done = player_done;
                in_stage    = 1'b1;
`ifdef DRAW_SEQUENCER_HUD_EN
                after_stage = S_HUD;
`endif
            end
`ifdef DRAW_SEQUENCER_HUD_EN
            S_HUD: begin
                active_done = hud_done;
                in_stage    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = '0;
        overrun_next = overrun_reg & ~clear_flags;
        timeout_next = timeout_reg & ~clear_flags;
        // A request arriving mid-frame is dropped, never queued.
        if (frame_start && (state_reg != S_IDLE)) begin
            overrun_next = 1'b1;
        end
        case (state_reg)
            S_IDLE: begin
                if (frame_start) begin
                    state_next = S_MAP;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: begin
                if (!in_stage) begin
                    state_next = S_IDLE;
                end else if (active_done) begin
                    state_next = after_stage;
                end else if (count_reg >= TIMEOUT_CYCLES) begin
                    state_next   = after_stage;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count_reg + 17'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            overrun_reg <= overrun_next;
            timeout_reg <= timeout_next;
        end
    end

    assign map_enable    = (state_reg == S_MAP);
    assign player_enable = (state_reg == S_PLAYER);
`ifdef DRAW_SEQUENCER_HUD_EN
    assign hud_enable    = (state_reg == S_HUD);
`endif
    assign busy          = (state_reg != S_IDLE);
    assign frame_done    = (state_reg == S_DONE);
    assign stage         = in_stage ? state_reg[1:0] : 2'd0;
    assign frame_overrun = overrun_reg;
    assign stage_timeout = timeout_reg;

    logic [BUS_W-1:0]       client_bus [NUM_CLIENTS];
    logic [BUS_W-1:0]       gated_bus  [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] client_sel;
    logic [BUS_W-1:0]       pixel_bus;

    assign client_bus[0] = {map_x, map_y, map_colour, map_write};
    assign client_bus[1] = {player_x, player_y, player_colour, player_write};
    assign client_sel[0] = map_enable;
    assign client_sel[1] = player_enable;
`ifdef DRAW_SEQUENCER_HUD_EN
    assign client_bus[2] = {hud_x, hud_y, hud_colour, hud_write};
    assign client_sel[2] = hud_enable;
`endif

    // Enables are one-hot (or all zero), so an AND-OR mux gives a zero bus outside the stages.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_gate
            assign gated_bus[gi] = client_bus[gi] & {BUS_W{client_sel[gi]}};
        end
    endgenerate

    always_comb begin
        pixel_bus = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            pixel_bus = pixel_bus | gated_bus[i];
        end
    end

    assign {x_pos, y_pos, colour, VGA_write} = pixel_bus;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: directed scenarios plus random traffic against a stage-list model.
`timescale 1ns/1ps
module tb_draw_sequencer;

    localparam logic [16:0] TMO = 17'd20;
`ifdef DRAW_SEQUENCER_HUD_EN
    localparam int N_STAGES = 3;
`else
    localparam int N_STAGES = 2;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       clear_flags = 1'b0;
    logic       map_enable, player_enable;
    logic       map_done = 1'b0, player_done = 1'b0;
    logic [8:0] map_x = '0, player_x = '0;
    logic [7:0] map_y = '0, player_y = '0;
    logic [5:0] map_colour = '0, player_colour = '0;
    logic       map_write = 1'b0, player_write = 1'b0;
`ifdef DRAW_SEQUENCER_HUD_EN
    logic       hud_enable;
    logic       hud_done = 1'b0;
    logic [8:0] hud_x = '0;
    logic [7:0] hud_y = '0;
    logic [5:0] hud_colour = '0;
    logic       hud_write = 1'b0;
`endif
    logic [8:0] x_pos;
    logic [7:0] y_pos;
    logic [5:0] colour;
    logic       VGA_write, busy, frame_done, frame_overrun, stage_timeout;
    logic [1:0] stage;

    draw_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .clear_flags(clear_flags),
        .map_enable(map_enable), .player_enable(player_enable),
        .map_done(map_done), .player_done(player_done),
        .map_x(map_x), .player_x(player_x), .map_y(map_y), .player_y(player_y),
        .map_colour(map_colour), .player_colour(player_colour),
        .map_write(map_write), .player_write(player_write),
`ifdef DRAW_SEQUENCER_HUD_EN
        .hud_enable(hud_enable), .hud_done(hud_done), .hud_x(hud_x), .hud_y(hud_y),
        .hud_colour(hud_colour), .hud_write(hud_write),
`endif
        .x_pos(x_pos), .y_pos(y_pos), .colour(colour), .VGA_write(VGA_write),
        .busy(busy), .stage(stage), .frame_done(frame_done),
        .frame_overrun(frame_overrun), .stage_timeout(stage_timeout)
    );

    always #5 clock = ~clock;

    int   vectors = 0, miscompares = 0, cycle = 0;
    // Model: pos 0 = idle, 1..N_STAGES = position in the stage list, N_STAGES+1 = end-of-frame cycle.
    int   m_pos = 0, m_age = 0, n_pos = 0, n_age = 0;
    logic m_ov = 1'b0, m_to = 1'b0, n_ov = 1'b0, n_to = 1'b0;
    int   done_delay = 5;
    int   map_rise, player_rise, fd_cycle, idle_cycle, fd_count;
    logic to_at_player;
`ifdef DRAW_SEQUENCER_HUD_EN
    int   hud_rise;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic logic [32:0] observed_word();
        logic hud_en;
        hud_en = 1'b0;
`ifdef DRAW_SEQUENCER_HUD_EN
        hud_en = hud_enable;
`endif
        return {map_enable, player_enable, hud_en, busy, stage, frame_done, frame_overrun,
                stage_timeout, x_pos, y_pos, colour, VGA_write};
    endfunction

    function automatic logic [32:0] expected_word();
        logic [23:0] pix;
        logic        in_st;
        pix   = '0;
        in_st = (m_pos >= 1) && (m_pos <= N_STAGES);
        if (m_pos == 1) pix = {map_x, map_y, map_colour, map_write};
        if (m_pos == 2) pix = {player_x, player_y, player_colour, player_write};
`ifdef DRAW_SEQUENCER_HUD_EN
        if (m_pos == 3) pix = {hud_x, hud_y, hud_colour, hud_write};
`endif
        return {m_pos == 1, m_pos == 2, (N_STAGES == 3) && (m_pos == 3), m_pos != 0,
                in_st ? 2'(m_pos) : 2'd0, m_pos == N_STAGES + 1, m_ov, m_to, pix};
    endfunction

    task automatic model_compute();
        logic act_done;
        n_pos = m_pos;
        n_age = m_age;
        n_ov  = clear_flags ? 1'b0 : m_ov;
        n_to  = clear_flags ? 1'b0 : m_to;
        if (frame_start && m_pos != 0) n_ov = 1'b1;
        act_done = 1'b0;
        if (m_pos == 1) act_done = map_done;
        if (m_pos == 2) act_done = player_done;
`ifdef DRAW_SEQUENCER_HUD_EN
        if (m_pos == 3) act_done = hud_done;
`endif
        if (m_pos == 0) begin
            if (frame_start) begin n_pos = 1; n_age = 0; end
        end else if (m_pos == N_STAGES + 1) begin
            n_pos = 0;
        end else if (act_done) begin
            n_pos = m_pos + 1; n_age = 0;
        end else if (m_age == int'(TMO)) begin
            n_pos = m_pos + 1; n_age = 0; n_to = 1'b1;
        end else begin
            n_age = m_age + 1;
        end
        if (!reset) begin n_pos = 0; n_age = 0; n_ov = 1'b0; n_to = 1'b0; end
    endtask

    task automatic clear_trackers();
        map_rise = -1; player_rise = -1; fd_cycle = -1; idle_cycle = -1; fd_count = 0;
        to_at_player = 1'bx;
`ifdef DRAW_SEQUENCER_HUD_EN
        hud_rise = -1;
`endif
    endtask

    // One clock cycle: compare all outputs, step the model, cross the edge, drop one-shot pulses.
    task automatic tick(input string tag);
        #1;
        check(tag, 64'(observed_word()), 64'(expected_word()));
        if (map_enable === 1'b1 && map_rise < 0) map_rise = cycle;
        if (player_enable === 1'b1 && player_rise < 0) begin
            player_rise = cycle; to_at_player = stage_timeout;
        end
`ifdef DRAW_SEQUENCER_HUD_EN
        if (hud_enable === 1'b1 && hud_rise < 0) hud_rise = cycle;
`endif
        if (frame_done === 1'b1) begin
            fd_count++;
            if (fd_cycle < 0) fd_cycle = cycle;
        end
        if (fd_cycle >= 0 && idle_cycle < 0 && busy === 1'b0) idle_cycle = cycle;
        model_compute();
        @(posedge clock);
        m_pos = n_pos; m_age = n_age; m_ov = n_ov; m_to = n_to;
        cycle++;
        #1;
        frame_start = 1'b0;
        clear_flags = 1'b0;
        reset = 1'b1;
    endtask

    task automatic auto_done();
        map_done    = (m_pos == 1) && (m_age == done_delay);
        player_done = (m_pos == 2) && (m_age == done_delay);
`ifdef DRAW_SEQUENCER_HUD_EN
        hud_done    = (m_pos == 3) && (m_age == done_delay);
`endif
    endtask

    task automatic rand_pixels();
        map_x = 9'($urandom); map_y = 8'($urandom); map_colour = 6'($urandom); map_write = 1'($urandom);
        player_x = 9'($urandom); player_y = 8'($urandom); player_colour = 6'($urandom);
        player_write = 1'($urandom);
`ifdef DRAW_SEQUENCER_HUD_EN
        hud_x = 9'($urandom); hud_y = 8'($urandom); hud_colour = 6'($urandom); hud_write = 1'($urandom);
`endif
    endtask

    initial begin
        int c0;
        clear_trackers();
        repeat (2) @(posedge clock);
        #1;
        tick("reset_state");

        // Nominal frame: each client finishes 5 cycles after its enable rises.
        for (int k = 0; k < 3; k++) begin rand_pixels(); tick("idle"); end
        c0 = cycle;
        done_delay = 5;
        frame_start = 1'b1;
        auto_done();
        tick("start");
        for (int k = 0; k < 25; k++) begin auto_done(); rand_pixels(); tick("nominal"); end
        check("map_rise", 64'(map_rise), 64'(c0 + 1));
        check("player_rise", 64'(player_rise), 64'(c0 + 7));
`ifdef DRAW_SEQUENCER_HUD_EN
        check("hud_rise", 64'(hud_rise), 64'(c0 + 13));
`endif
        check("frame_done_cycle", 64'(fd_cycle), 64'(c0 + 1 + 6 * N_STAGES));
        check("busy_low_cycle", 64'(idle_cycle), 64'(c0 + 2 + 6 * N_STAGES));
        check("frame_done_count", 64'(fd_count), 64'd1);

        // Pixel mux passes the map client only, even with other clients writing.
        done_delay = -1;
        frame_start = 1'b1;
        auto_done();
        tick("start_mux");
        map_x = 9'd319; map_y = 8'd239; map_colour = 6'h2A; map_write = 1'b1; player_write = 1'b1;
        #1;
        check("mux_xyc", 64'({x_pos, y_pos, colour, VGA_write}), 64'({9'd319, 8'd239, 6'h2A, 1'b1}));
        tick("mux_map");
        map_write = 1'b0; player_write = 1'b1;
        #1;
        check("mux_write_only_map", 64'(VGA_write), 64'd0);
        tick("mux_map2");
        done_delay = 2;
        for (int k = 0; k < 20; k++) begin auto_done(); rand_pixels(); tick("mux_finish"); end

        // Map client never finishes: timeout forces PLAYER 21 cycles after map_enable rose.
        clear_trackers();
        done_delay = 3;
        frame_start = 1'b1;
        tick("start_tmo");
        for (int k = 0; k < 40; k++) begin auto_done(); map_done = 1'b0; rand_pixels(); tick("timeout"); end
        check("timeout_span", 64'(player_rise - map_rise), 64'd21);
        check("timeout_flag", 64'(to_at_player), 64'd1);
        clear_flags = 1'b1;
        tick("clear_tmo");
        #1;
        check("timeout_cleared", 64'(stage_timeout), 64'd0);

        // Done arrives on the very cycle the timeout would fire: done wins.
        clear_trackers();
        frame_start = 1'b1;
        tick("start_race");
        for (int k = 0; k < 40; k++) begin
            auto_done();
            map_done = (m_pos == 1) && (m_age == int'(TMO));
            tick("race");
        end
        check("race_span", 64'(player_rise - map_rise), 64'd21);
        check("race_no_flag", 64'(to_at_player), 64'd0);

        // Overrun: a request during PLAYER is dropped and flagged.
        clear_trackers();
        done_delay = 5;
        frame_start = 1'b1;
        tick("start_ovr");
        for (int k = 0; k < 30; k++) begin
            auto_done();
            if (m_pos == 2 && m_age == 1) frame_start = 1'b1;
            tick("overrun");
        end
        check("overrun_one_frame", 64'(fd_count), 64'd1);
        #1;
        check("overrun_flag", 64'(frame_overrun), 64'd1);
        clear_flags = 1'b1;
        tick("clear_ovr");
        #1;
        check("overrun_cleared", 64'(frame_overrun), 64'd0);

        // Reset during PLAYER aborts the frame with no frame_done afterwards.
        clear_trackers();
        frame_start = 1'b1;
        tick("start_rst");
        for (int k = 0; k < 40 && !(m_pos == 2 && m_age == 2); k++) begin auto_done(); tick("pre_rst"); end
        reset = 1'b0;
        rand_pixels();
        tick("reset_mid");
        #1;
        check("after_reset_zero", 64'(observed_word()), 64'd0);
        for (int k = 0; k < 30; k++) begin auto_done(); rand_pixels(); tick("post_rst"); end
        check("no_done_after_reset", 64'(fd_count), 64'd0);
        clear_trackers();
        frame_start = 1'b1;
        tick("restart");
        for (int k = 0; k < 25; k++) begin auto_done(); tick("restart_run"); end
        check("restart_done_count", 64'(fd_count), 64'd1);

        // Start and clear together in IDLE: frame starts, flags clear.
        frame_start = 1'b1;
        tick("start_f");
        frame_start = 1'b1;
        tick("set_ovr");
        for (int k = 0; k < 25; k++) begin auto_done(); tick("finish_f"); end
        frame_start = 1'b1;
        clear_flags = 1'b1;
        tick("start_and_clear");
        #1;
        check("start_clear_flag", 64'({frame_overrun, map_enable}), 64'({1'b0, 1'b1}));
        for (int k = 0; k < 25; k++) begin auto_done(); tick("finish_g"); end

        // Random traffic, including done pulses from inactive clients and stray resets.
        for (int k = 0; k < 600; k++) begin
            rand_pixels();
            frame_start = ($urandom_range(0, 7) == 0);
            clear_flags = ($urandom_range(0, 15) == 0);
            map_done    = ($urandom_range(0, 7) == 0);
            player_done = ($urandom_range(0, 7) == 0);
`ifdef DRAW_SEQUENCER_HUD_EN
            hud_done    = ($urandom_range(0, 7) == 0);
`endif
            reset       = !($urandom_range(0, 63) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
